// File: rtl/ntru_pkg.sv
// Shared constants, coefficient codes and state encoding for the ternary
// operand path of the Rq multiplier.
package ntru_pkg;

    localparam int unsigned NUM_N           = 701;
    localparam int unsigned COEF_W          = 2;
    localparam int unsigned BEAT_COEFS      = 8;
    localparam int unsigned NUM_BEATS       = (NUM_N + BEAT_COEFS - 1) / BEAT_COEFS;
    localparam int unsigned LAST_BEAT_COEFS = NUM_N - (NUM_BEATS - 1) * BEAT_COEFS;
    localparam int unsigned IDX_W           = $clog2(NUM_N);
    localparam int unsigned BEAT_W          = $clog2(NUM_BEATS);
    localparam int unsigned WR_W            = BEAT_COEFS * COEF_W;

    typedef logic [COEF_W-1:0] coef_t;

    localparam coef_t TERN_ZERO    = 2'b00;
    localparam coef_t TERN_POS     = 2'b01;
    localparam coef_t TERN_NEG     = 2'b10;
    localparam coef_t TERN_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_READY  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } streamer_state_t;

    // Illegal code is stored as zero so the multiplier never sees it.
    function automatic coef_t scrub_coef(input coef_t c);
        return (c == TERN_ILLEGAL) ? TERN_ZERO : c;
    endfunction

endpackage

// File: rtl/tern_coef_buffer.sv
// Coefficient store: beat-wide scrubbed write port, single combinational read port.
module tern_coef_buffer
    import ntru_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] wr_beat,
    input  logic [WR_W-1:0]   wr_data,
    output logic              wr_illegal,
    input  logic [IDX_W-1:0]  rd_idx,
    output coef_t             rd_data
);

    coef_t            mem [NUM_N];
    logic [IDX_W-1:0] base;

    assign base    = IDX_W'(wr_beat) * IDX_W'(BEAT_COEFS);
    assign rd_data = mem[rd_idx];

    // Lanes past the end of the polynomial are neither stored nor flagged.
    always_comb begin
        wr_illegal = 1'b0;
        for (int j = 0; j < int'(BEAT_COEFS); j++) begin
            if ((base + IDX_W'(j)) < IDX_W'(NUM_N) &&
                coef_t'(wr_data[j*COEF_W +: COEF_W]) == TERN_ILLEGAL) begin
                wr_illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < int'(BEAT_COEFS); j++) begin
                if ((base + IDX_W'(j)) < IDX_W'(NUM_N)) begin
                    mem[base + IDX_W'(j)] <= scrub_coef(coef_t'(wr_data[j*COEF_W +: COEF_W]));
                end
            end
        end
    end

endmodule

// File: rtl/ternary_coef_streamer.sv
// Buffers a ternary polynomial written as packed beats and streams it one
// coefficient per cycle over valid/ready, with replay from the buffer.
module ternary_coef_streamer
    import ntru_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_start,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [BEAT_COEFS*COEF_W-1:0]   wr_data,
    input  logic                           go,
    output logic                           coef_valid,
    input  logic                           coef_ready,
    output logic [COEF_W-1:0]              coef_data,
    output logic [IDX_W-1:0]               coef_idx,
    output logic                           coef_last,
    output logic                           loaded,
    output logic                           busy,
    output logic                           done,
    output logic                           err_illegal
);

    streamer_state_t   state_q, state_d;
    logic [BEAT_W-1:0] beat_q;
    logic [IDX_W-1:0]  idx_q;
    logic              err_q;

    logic  restart, wr_fire, beat_last, idx_last, stream_fire, start_stream;
    logic  wr_illegal;
    coef_t rd_data;

    // load_start wins over a beat or go arriving in the same cycle; STREAM ignores it.
    assign restart      = load_start && (state_q != ST_STREAM);
    assign wr_fire      = (state_q == ST_LOAD) && wr_valid && !load_start;
    assign beat_last    = (beat_q == BEAT_W'(NUM_BEATS - 1));
    assign idx_last     = (idx_q == IDX_W'(NUM_N - 1));
    assign stream_fire  = (state_q == ST_STREAM) && coef_ready;
    assign start_stream = ((state_q == ST_READY) || (state_q == ST_DONE)) && go && !load_start;

    tern_coef_buffer u_buf (
        .clk        (clk),
        .wr_en      (wr_fire),
        .wr_beat    (beat_q),
        .wr_data    (wr_data),
        .wr_illegal (wr_illegal),
        .rd_idx     (idx_q),
        .rd_data    (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!load_start && wr_fire && beat_last) state_d = ST_READY;
            end
            ST_READY, ST_DONE: begin
                if (load_start)  state_d = ST_LOAD;
                else if (go)     state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (stream_fire && idx_last) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat counter, sticky illegal flag and stream index.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            err_q  <= 1'b0;
            idx_q  <= '0;
        end else begin
            if (restart) begin
                beat_q <= '0;
                err_q  <= 1'b0;
            end else if (wr_fire) begin
                beat_q <= beat_q + BEAT_W'(1);
                if (wr_illegal) err_q <= 1'b1;
            end
            if (start_stream) begin
                idx_q <= '0;
            end else if (stream_fire && !idx_last) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        wr_ready    = 1'b0;
        coef_valid  = 1'b0;
        coef_last   = 1'b0;
        coef_data   = TERN_ZERO;
        loaded      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        coef_idx    = idx_q;
        err_illegal = err_q;
        case (state_q)
            ST_LOAD: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_READY: begin
                loaded = 1'b1;
            end
            ST_STREAM: begin
                coef_valid = 1'b1;
                coef_last  = idx_last;
                coef_data  = rd_data;
                loaded     = 1'b1;
                busy       = 1'b1;
            end
            ST_DONE: begin
                loaded = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ternary_coef_streamer.md
Name: ternary_coef_streamer

Overview:
- Transmit side of the serial ternary-operand interface of the Rq polynomial multiplier.
- Accepts a ternary polynomial r (NUM_N coefficients, 2 bits each) from the host as packed word beats and buffers it internally.
- Streams the coefficients one per cycle, lowest index first, over a valid/ready handshake that drives the multiplier's r input.
- Supports replay of the buffered polynomial without reloading.

Parameters:
- NUM_N, 701, number of polynomial coefficients.
- COEF_W, 2, bits per ternary coefficient.
- BEAT_COEFS, 8, coefficients per write beat.
- IDX_W, 10, width of coefficient index, ceil(log2(NUM_N)).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- load_start  input  1  begin loading a new polynomial.
- wr_valid  input  1  write beat valid.
- wr_ready  output  1  streamer accepts a beat.
- wr_data  input  BEAT_COEFS*COEF_W  packed coefficients; coefficient j of the beat sits in bits [j*2+1:j*2].
- go  input  1  start streaming the buffered polynomial.
- coef_valid  output  1  coef_data valid.
- coef_ready  input  1  multiplier consumes the coefficient.
- coef_data  output  COEF_W  current coefficient code.
- coef_idx  output  IDX_W  index of current coefficient.
- coef_last  output  1  current coefficient is index NUM_N-1.
- loaded  output  1  buffer holds a complete polynomial.
- busy  output  1  in LOAD or STREAM.
- done  output  1  streaming finished (level).
- err_illegal  output  1  sticky; an illegal code was written.

Behaviour:
- Coefficient encoding: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1 (q-1).
  - 2'b11 is illegal: it is stored as 2'b00 and sets err_illegal.
- NUM_BEATS = ceil(NUM_N/BEAT_COEFS) = 88.
  - The last beat carries NUM_N - 87*8 = 5 valid coefficients; its upper lanes are ignored and do not affect err_illegal.
- FSM states: IDLE, LOAD, READY, STREAM, DONE.
- Reset:
  - state IDLE; beat counter and coef_idx = 0.
  - wr_ready, coef_valid, coef_last, loaded, busy, done, err_illegal = 0; coef_data = 0.
  - Buffer contents are not cleared and are don't-care.
- IDLE:
  - load_start -> LOAD. Beat counter = 0, err_illegal cleared.
  - go is ignored.
- LOAD:
  - wr_ready = 1 and busy = 1.
  - A beat is accepted when wr_valid & wr_ready; beat k writes coefficients k*8 .. k*8+7.
  - Acceptance of beat 87 -> READY the next cycle, with loaded = 1.
  - load_start in LOAD restarts the load: counter = 0, err cleared.
- READY:
  - go -> STREAM with coef_idx = 0.
  - load_start -> LOAD, loaded = 0. load_start has priority over a simultaneous go.
- STREAM:
  - coef_valid = 1 and busy = 1; coef_data = buf[coef_idx]; coef_last = (coef_idx == NUM_N-1).
  - The first coefficient is valid the cycle after go.
  - On coef_valid & coef_ready: coef_idx increments. If coef_last, go to DONE instead.
  - When coef_ready = 0, coef_data, coef_idx and coef_last hold stable.
  - load_start and go are ignored.
  - Throughput is 1 coefficient/cycle with coef_ready held high, so a full stream takes NUM_N cycles.
- DONE:
  - done = 1, coef_valid = 0, loaded stays 1.
  - go -> STREAM from index 0 (replay).
  - load_start -> LOAD (priority over go).
- rst asserted in any state, including mid-load or mid-stream, returns to IDLE with reset outputs on the next edge.
  - The partially loaded buffer is not reused.
- Buffer:
  - NUM_N x COEF_W register array.
  - Read is combinational on coef_idx; write is BEAT_COEFS lanes wide at base beat*8.

Decomposition:
- Shared package ntru_pkg holds:
  - NUM_N, COEF_W, BEAT_COEFS, the derived NUM_BEATS / LAST_BEAT_COEFS / IDX_W constants.
  - Typedef coef_t (logic [1:0]) and the code constants TERN_ZERO/TERN_POS/TERN_NEG.
  - Enum streamer_state_t.
- One sub-module, tern_coef_buffer: register array with beat-wide write port, illegal-code scrub and single read port.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then idle for 5 cycles -> all outputs 0; go alone does not leave IDLE (coef_valid stays 0).
- Load 88 beats where coefficient i = i%3, then go, coef_ready = 1 -> 701 consecutive valid cycles; data matches i%3; coef_last only at idx 700; done = 1 on the next cycle.
- Same stream with coef_ready toggling 1,0,0,1,... -> no skipped or duplicated indices; data and idx stable while ready = 0; still ends at idx 700.
- Beat 3 lane 2 = 2'b11, beat 87 lanes 5-7 = 2'b11 -> err_illegal = 1 (from beat 3 only); coefficient 26 streams as 2'b00; coefficients 701+ never appear.
- After DONE, pulse go twice with no reload -> identical 701-coefficient stream each time; then load_start -> err_illegal cleared, loaded = 0, wr_ready = 1.
- rst at stream idx 350 -> IDLE the next cycle, coef_valid = 0, loaded = 0; load_start asserted during STREAM before that rst has no effect.
